hdlverifier_capture_trigger_sequencer: RTL and testbench



---
 rtl/hdlverifier_trigger_pkg.sv | 28 ++
 rtl/hdlverifier_trigger_condition.sv | 34 +++
 rtl/hdlverifier_capture_trigger_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_hdlverifier_capture_trigger_sequencer.sv | 340 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hdlverifier_trigger_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hdlverifier_trigger_pkg
// Description : Shared types and encodings for the capture trigger sequencer.
//               Contents:
//                 trig_state_e      - sequencer state (IDLE/ARMED/TRIGGERED)
//                 TRIG_LEVEL_HIGH/LOW, TRIG_RISE/FALL - 2-bit channel modes
//                 RULE_OR / RULE_AND                   - stage combination rule
// Revision    : 1.0 - initial release
// ============================================================================
package hdlverifier_trigger_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_TRIGGERED = 2'd2
  } trig_state_e;

  localparam logic [1:0] TRIG_LEVEL_HIGH = 2'b00;
  localparam logic [1:0] TRIG_LEVEL_LOW  = 2'b01;
  localparam logic [1:0] TRIG_RISE       = 2'b10;
  localparam logic [1:0] TRIG_FALL       = 2'b11;

  localparam logic RULE_OR  = 1'b1;
  localparam logic RULE_AND = 1'b0;

endpackage : hdlverifier_trigger_pkg
`default_nettype wire

// File: rtl/hdlverifier_trigger_condition.sv
`default_nettype none
// ============================================================================
// Module      : hdlverifier_trigger_condition
// Description : Combinational per-channel qualifier. Turns the registered
//               current/previous samples into a condition vector according
//               to each channel's 2-bit mode.
// Ports       : cur_i  [WIDTH]   - current registered sample
//               prev_i [WIDTH]   - previous registered sample
//               mode_i [2*WIDTH] - channel k mode at bits [2k +: 2]
//               cond_o [WIDTH]   - per-channel condition met
// Revision    : 1.0 - initial release
// ============================================================================
module hdlverifier_trigger_condition
  import hdlverifier_trigger_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]   cur_i,
  input  logic [WIDTH-1:0]   prev_i,
  input  logic [2*WIDTH-1:0] mode_i,
  output logic [WIDTH-1:0]   cond_o
);

  for (genvar g = 0; g < WIDTH; g++) begin : g_ch
    logic [1:0] w_mode;
    assign w_mode    = mode_i[2*g +: 2];
    assign cond_o[g] = (w_mode == TRIG_LEVEL_HIGH) ?  cur_i[g] :
                       (w_mode == TRIG_LEVEL_LOW)  ? ~cur_i[g] :
                       (w_mode == TRIG_RISE)       ? ( cur_i[g] & ~prev_i[g]) :
                                                     (~cur_i[g] &  prev_i[g]);
  end : g_ch

endmodule : hdlverifier_trigger_condition
`default_nettype wire

// File: rtl/hdlverifier_capture_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : hdlverifier_capture_trigger_sequencer
// Description : Multi-stage trigger engine. Up to STAGES conditions, each with
//               its own channel mask, AND/OR rule and consecutive-hit count,
//               must be met in order before a one-cycle trigger pulse.
// Ports       : clk, rst_n (async, active-low), clk_enable (global advance)
//               trigger_in [WIDTH], channel_mode [2*WIDTH]
//               stage_enable [STAGES*WIDTH], stage_rule [STAGES]
//               stage_count [STAGES*CNT_WIDTH], num_stages
//               arm (level; rising edge starts, low aborts)
//               trigger_out (pulse), triggered, armed, stage_idx
// Revision    : 1.0 - initial release
// ============================================================================
module hdlverifier_capture_trigger_sequencer
  import hdlverifier_trigger_pkg::*;
#(
  parameter  int WIDTH     = 8,
  parameter  int STAGES    = 4,
  parameter  int CNT_WIDTH = 16,
  localparam int NS_W      = $clog2(STAGES + 1),
  localparam int IDX_W     = (STAGES > 1) ? $clog2(STAGES) : 1
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_enable,
  input  logic [WIDTH-1:0]            trigger_in,
  input  logic [2*WIDTH-1:0]          channel_mode,
  input  logic [STAGES*WIDTH-1:0]     stage_enable,
  input  logic [STAGES-1:0]           stage_rule,
  input  logic [STAGES*CNT_WIDTH-1:0] stage_count,
  input  logic [NS_W-1:0]             num_stages,
  input  logic                        arm,
  output logic                        trigger_out,
  output logic                        triggered,
  output logic                        armed,
  output logic [IDX_W-1:0]            stage_idx
);

  // Input sampling; runs on every enabled cycle regardless of state.
  logic [WIDTH-1:0] cur_q, prev_q;
  logic             arm_prev_q;

  // Shadow configuration, captured only on the arm rising edge.
  logic [2*WIDTH-1:0]          mode_q,   mode_d;
  logic [STAGES*WIDTH-1:0]     enable_q, enable_d;
  logic [STAGES-1:0]           rule_q,   rule_d;
  logic [STAGES*CNT_WIDTH-1:0] count_q,  count_d;
  logic [IDX_W-1:0]            last_q,   last_d;

  trig_state_e                 state_q, state_d;
  logic [IDX_W-1:0]            idx_q,   idx_d;
  logic [CNT_WIDTH-1:0]        cnt_q,   cnt_d;
  logic                        trig_q,  trig_d;

  logic [WIDTH-1:0]     w_cond;
  logic [WIDTH-1:0]     w_mask;
  logic                 w_rule;
  logic [CNT_WIDTH-1:0] w_count;
  logic [CNT_WIDTH-1:0] w_need;
  logic [CNT_WIDTH-1:0] w_cnt_inc;
  logic                 w_hit;
  logic [IDX_W-1:0]     w_last;

  hdlverifier_trigger_condition #(
    .WIDTH (WIDTH)
  ) u_cond (
    .cur_i  (cur_q),
    .prev_i (prev_q),
    .mode_i (mode_q),
    .cond_o (w_cond)
  );

  // Only the current stage's settings are ever needed, so one condition
  // block serves every stage through this mux.
  assign w_mask  = enable_q[idx_q*WIDTH +: WIDTH];
  assign w_rule  = rule_q[idx_q];
  assign w_count = count_q[idx_q*CNT_WIDTH +: CNT_WIDTH];
  assign w_need  = (w_count == '0) ? CNT_WIDTH'(1) : w_count;

  // An all-zero mask hits under both rules.
  assign w_hit = (w_rule == RULE_OR) ? ((|(w_cond & w_mask)) | (&(~w_mask)))
                                     : (&(w_cond | ~w_mask));

  // Saturating increment: the counter never wraps back to zero.
  assign w_cnt_inc = (&cnt_q) ? cnt_q : (cnt_q + 1'b1);

  // Index of the final stage: 0 means one stage, oversize clamps to STAGES.
  assign w_last = (num_stages == '0)             ? '0 :
                  (num_stages > NS_W'(STAGES))   ? IDX_W'(STAGES - 1) :
                                                   IDX_W'(num_stages - 1'b1);

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    trig_d   = trig_q;
    mode_d   = mode_q;
    enable_d = enable_q;
    rule_d   = rule_q;
    count_d  = count_q;
    last_d   = last_q;

    if (clk_enable) begin
      trig_d = 1'b0;
      if (!arm) begin
        // Abort takes priority over any hit evaluated this cycle.
        state_d = ST_IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (!arm_prev_q) begin
              mode_d   = channel_mode;
              enable_d = stage_enable;
              rule_d   = stage_rule;
              count_d  = stage_count;
              last_d   = w_last;
              state_d  = ST_ARMED;
              idx_d    = '0;
              cnt_d    = '0;
            end
          end
          ST_ARMED: begin
            if (w_hit) begin
              if (w_cnt_inc >= w_need) begin
                cnt_d = '0;
                if (idx_q == last_q) begin
                  state_d = ST_TRIGGERED;
                  trig_d  = 1'b1;
                end else begin
                  idx_d = idx_q + 1'b1;
                end
              end else begin
                cnt_d = w_cnt_inc;
              end
            end else begin
              cnt_d = '0;
            end
          end
          ST_TRIGGERED: state_d = ST_TRIGGERED;
          default:      state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur_q      <= '0;
      prev_q     <= '0;
      arm_prev_q <= 1'b0;
    end else if (clk_enable) begin
      cur_q      <= trigger_in;
      prev_q     <= cur_q;
      arm_prev_q <= arm;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= ST_IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      trig_q   <= 1'b0;
      mode_q   <= '0;
      enable_q <= '0;
      rule_q   <= '0;
      count_q  <= '0;
      last_q   <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      trig_q   <= trig_d;
      mode_q   <= mode_d;
      enable_q <= enable_d;
      rule_q   <= rule_d;
      count_q  <= count_d;
      last_q   <= last_d;
    end
  end

  assign trigger_out = trig_q;
  assign triggered   = (state_q == ST_TRIGGERED);
  assign armed       = (state_q == ST_ARMED);
  assign stage_idx   = idx_q;

endmodule : hdlverifier_capture_trigger_sequencer
`default_nettype wire

// File: tb/tb_hdlverifier_capture_trigger_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_hdlverifier_capture_trigger_sequencer
// Description : Self-checking bench for the capture trigger sequencer.
//               Expected values are {trigger_out, triggered, armed, stage_idx}.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_hdlverifier_capture_trigger_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        clk_enable;
  logic [7:0]  trigger_in;
  logic [15:0] channel_mode;
  logic [31:0] stage_enable;
  logic [3:0]  stage_rule;
  logic [63:0] stage_count;
  logic [2:0]  num_stages;
  logic        arm;
  logic        trigger_out;
  logic        triggered;
  logic        armed;
  logic [1:0]  stage_idx;

  always #5 clk = ~clk;

  hdlverifier_capture_trigger_sequencer #(
    .WIDTH     (8),
    .STAGES    (4),
    .CNT_WIDTH (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clk_enable   (clk_enable),
    .trigger_in   (trigger_in),
    .channel_mode (channel_mode),
    .stage_enable (stage_enable),
    .stage_rule   (stage_rule),
    .stage_count  (stage_count),
    .num_stages   (num_stages),
    .arm          (arm),
    .trigger_out  (trigger_out),
    .triggered    (triggered),
    .armed        (armed),
    .stage_idx    (stage_idx)
  );

  // {trigger_out, triggered, armed, stage_idx}
  localparam logic [4:0] E_IDLE   = 5'b0_0_0_00;
  localparam logic [4:0] E_ARM0   = 5'b0_0_1_00;
  localparam logic [4:0] E_ARM1   = 5'b0_0_1_01;
  localparam logic [4:0] E_PULSE0 = 5'b1_1_0_00;
  localparam logic [4:0] E_TRG0   = 5'b0_1_0_00;
  localparam logic [4:0] E_PULSE1 = 5'b1_1_0_01;
  localparam logic [4:0] E_TRG1   = 5'b0_1_0_01;

  typedef struct {
    logic       arm;
    logic       en;
    logic [7:0] tin;
    logic [4:0] exp;
  } vec_t;

  int tests = 0;
  int fails = 0;
  bit use_model = 1'b0;

  // Reference model state: phase 0 idle, 1 waiting on a stage, 2 done.
  int          m_phase, m_stage, m_run, m_last;
  logic        m_out, m_armprev;
  logic [7:0]  m_cur, m_prev;
  logic [15:0] sh_mode;
  logic [31:0] sh_en;
  logic [3:0]  sh_rule;
  logic [63:0] sh_cnt;

  function automatic vec_t mk(logic a, logic e, logic [7:0] t, logic [4:0] x);
    vec_t v;
    v.arm = a; v.en = e; v.tin = t; v.exp = x;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [4:0] exp);
    logic [4:0] act;
    act = {trigger_out, triggered, armed, stage_idx};
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got {out,trg,armed,idx}=%b want %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_stage = 0; m_run = 0; m_last = 0;
    m_out = 1'b0; m_armprev = 1'b0; m_cur = '0; m_prev = '0;
    sh_mode = '0; sh_en = '0; sh_rule = '0; sh_cnt = '0;
  endtask

  // One enabled clock of the sequencer rules, evaluated on pre-edge state.
  task automatic model_update();
    int  ena, sat, need, n;
    bit  c, hit;
    ena = 0; sat = 0;
    for (int ch = 0; ch < 8; ch++) begin
      case (sh_mode[2*ch +: 2])
        2'b00:   c = m_cur[ch];
        2'b01:   c = !m_cur[ch];
        2'b10:   c = m_cur[ch] && !m_prev[ch];
        default: c = !m_cur[ch] && m_prev[ch];
      endcase
      if (sh_en[m_stage*8 + ch]) begin
        ena++;
        if (c) sat++;
      end
    end
    if (sh_rule[m_stage]) hit = (ena == 0) || (sat > 0);
    else                  hit = (sat == ena);
    need = int'(sh_cnt[m_stage*16 +: 16]);
    if (need == 0) need = 1;

    m_out = 1'b0;
    if (!arm) begin
      m_phase = 0; m_stage = 0; m_run = 0;
    end else if (m_phase == 0) begin
      if (!m_armprev) begin
        sh_mode = channel_mode; sh_en = stage_enable;
        sh_rule = stage_rule;   sh_cnt = stage_count;
        n = int'(num_stages);
        if (n == 0) n = 1;
        if (n > 4)  n = 4;
        m_last = n - 1;
        m_phase = 1; m_stage = 0; m_run = 0;
      end
    end else if (m_phase == 1) begin
      if (hit) begin
        m_run++;
        if (m_run >= need) begin
          m_run = 0;
          if (m_stage == m_last) begin
            m_phase = 2; m_out = 1'b1;
          end else begin
            m_stage++;
          end
        end
      end else begin
        m_run = 0;
      end
    end
    m_prev = m_cur;
    m_cur = trigger_in;
    m_armprev = arm;
  endtask

  task automatic step();
    if (use_model && clk_enable) model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic av(input logic a, input logic e, input logic [7:0] t,
                    input logic [4:0] x, input string nm);
    arm = a; clk_enable = e; trigger_in = t;
    step();
    chk(nm, x);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; arm = 1'b0; clk_enable = 1'b1; trigger_in = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic cfg1(input logic [7:0] mask, input logic [15:0] mode);
    channel_mode = mode;
    stage_enable = {24'h0, mask};
    stage_rule   = 4'b0001;
    stage_count  = {48'h0, 16'd1};
    num_stages   = 3'd1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl[12];

    rst_n = 1'b0; arm = 1'b0; clk_enable = 1'b1; trigger_in = '0;
    cfg1(8'h01, 16'h0000);
    #2;
    chk("reset_state", E_IDLE);
    do_reset();

    // Single stage, OR, mask 0x01, level-high, count 1, with enable gaps.
    tbl[0]  = mk(0, 1, 8'h00, E_IDLE);
    tbl[1]  = mk(1, 1, 8'h00, E_ARM0);
    tbl[2]  = mk(1, 1, 8'h00, E_ARM0);
    tbl[3]  = mk(1, 1, 8'h01, E_ARM0);
    tbl[4]  = mk(1, 1, 8'h01, E_PULSE0);
    tbl[5]  = mk(1, 0, 8'h00, E_PULSE0);
    tbl[6]  = mk(1, 0, 8'h01, E_PULSE0);
    tbl[7]  = mk(1, 1, 8'h01, E_TRG0);
    tbl[8]  = mk(1, 1, 8'h00, E_TRG0);
    tbl[9]  = mk(0, 0, 8'h00, E_TRG0);
    tbl[10] = mk(0, 1, 8'h00, E_IDLE);
    tbl[11] = mk(1, 1, 8'h00, E_ARM0);
    for (int i = 0; i < 12; i++) begin
      arm = tbl[i].arm; clk_enable = tbl[i].en; trigger_in = tbl[i].tin;
      step();
      chk($sformatf("tbl_single[%0d]", i), tbl[i].exp);
    end
    av(0, 1, 8'h00, E_IDLE, "tbl_disarm");

    // Same sequence with clk_enable every other cycle.
    av(1, 1, 8'h00, E_ARM0,   "en2_arm");
    av(1, 0, 8'h01, E_ARM0,   "en2_gap0");
    av(1, 1, 8'h01, E_ARM0,   "en2_sample");
    av(1, 0, 8'h01, E_ARM0,   "en2_gap1");
    av(1, 1, 8'h01, E_PULSE0, "en2_pulse");
    av(1, 0, 8'h01, E_PULSE0, "en2_pulse_hold");
    av(1, 1, 8'h01, E_TRG0,   "en2_trg");
    av(0, 1, 8'h00, E_IDLE,   "en2_idle");
    av(1, 0, 8'h00, E_IDLE,   "en2_arm_disabled");
    av(1, 1, 8'h00, E_ARM0,   "en2_arm_late");
    av(0, 1, 8'h00, E_IDLE,   "en2_idle2");

    // Two stages: rise on ch0, then AND 0x06 level-high for 3 cycles.
    channel_mode = 16'h0002;
    stage_enable = {16'h0, 8'h06, 8'h01};
    stage_rule   = 4'b0001;
    stage_count  = {32'h0, 16'd3, 16'd1};
    num_stages   = 3'd2;
    av(1, 1, 8'h00, E_ARM0,   "two_arm");
    av(1, 1, 8'h01, E_ARM0,   "two_rise_in");
    av(1, 1, 8'h00, E_ARM1,   "two_stage1");
    av(1, 1, 8'h06, E_ARM1,   "two_s1");
    av(1, 1, 8'h06, E_ARM1,   "two_s2");
    av(1, 1, 8'h00, E_ARM1,   "two_s3");
    av(1, 1, 8'h06, E_ARM1,   "two_s4_reset_run");
    av(1, 1, 8'h06, E_ARM1,   "two_s5");
    av(1, 1, 8'h06, E_ARM1,   "two_s6");
    av(1, 1, 8'h00, E_PULSE1, "two_pulse");
    av(1, 1, 8'h00, E_TRG1,   "two_hold");
    av(0, 1, 8'h00, E_IDLE,   "two_idle");

    // Asynchronous reset in the middle of stage 1.
    av(1, 1, 8'h00, E_ARM0, "rst_arm");
    av(1, 1, 8'h01, E_ARM0, "rst_rise_in");
    av(1, 1, 8'h06, E_ARM1, "rst_stage1");
    av(1, 1, 8'h06, E_ARM1, "rst_s2");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_async", E_IDLE);
    arm = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    av(0, 1, 8'h00, E_IDLE, "rst_after");

    // Falling edge on ch7 with constant high input, then a drop.
    cfg1(8'h80, 16'hC000);
    av(0, 1, 8'h80, E_IDLE,   "fall_pre0");
    av(0, 1, 8'h80, E_IDLE,   "fall_pre1");
    av(1, 1, 8'h80, E_ARM0,   "fall_arm");
    for (int i = 0; i < 3; i++) av(1, 1, 8'h80, E_ARM0, "fall_const");
    av(1, 1, 8'h00, E_ARM0,   "fall_drop");
    av(1, 1, 8'h00, E_PULSE0, "fall_pulse");
    av(0, 1, 8'h00, E_IDLE,   "fall_idle");

    // Abort coincident with the final hit.
    cfg1(8'h01, 16'h0000);
    av(1, 1, 8'h00, E_ARM0, "abort_arm");
    av(1, 1, 8'h01, E_ARM0, "abort_in");
    av(0, 1, 8'h01, E_IDLE, "abort");
    av(0, 1, 8'h01, E_IDLE, "abort_hold");

    // Config change while armed is ignored.
    cfg1(8'h01, 16'h0000);
    av(0, 1, 8'h00, E_IDLE,   "cfg_pre");
    av(1, 1, 8'h00, E_ARM0,   "cfg_arm");
    stage_enable = 32'h0000_00FF;
    av(1, 1, 8'h02, E_ARM0,   "cfg_ign0");
    av(1, 1, 8'h02, E_ARM0,   "cfg_ign1");
    av(1, 1, 8'h01, E_ARM0,   "cfg_ign2");
    av(1, 1, 8'h01, E_PULSE0, "cfg_pulse");
    av(0, 1, 8'h00, E_IDLE,   "cfg_idle");

    // num_stages = 0 and stage_count = 0 both behave as 1.
    channel_mode = 16'h0000;
    stage_enable = {16'h0, 8'hFF, 8'h01};
    stage_rule   = 4'b0001;
    stage_count  = 64'h0;
    num_stages   = 3'd0;
    av(1, 1, 8'h00, E_ARM0,   "ns0_arm");
    av(1, 1, 8'h01, E_ARM0,   "ns0_in");
    av(1, 1, 8'h01, E_PULSE0, "ns0_cnt0_pulse");
    av(0, 1, 8'h00, E_IDLE,   "ns0_idle");

    // num_stages above STAGES clamps; empty masks always hit; one stage/cycle.
    stage_enable = 32'h0;
    stage_rule   = 4'b0101;
    stage_count  = {16'd1, 16'd1, 16'd1, 16'd1};
    num_stages   = 3'd7;
    av(1, 1, 8'h00, 5'b0_0_1_00, "clamp_arm");
    av(1, 1, 8'h00, 5'b0_0_1_01, "clamp_idx1");
    av(1, 1, 8'h00, 5'b0_0_1_10, "clamp_idx2");
    av(1, 1, 8'h00, 5'b0_0_1_11, "clamp_idx3");
    av(1, 1, 8'h00, 5'b1_1_0_11, "clamp_pulse");
    av(0, 1, 8'h00, E_IDLE,      "clamp_idle");

    // Randomized run against the reference model.
    do_reset();
    use_model = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      clk_enable = ($urandom_range(0, 3) != 0);
      if (arm) arm = ($urandom_range(0, 39) != 0);
      else     arm = ($urandom_range(0, 2) == 0);
      trigger_in   = 8'($urandom);
      channel_mode = 16'($urandom);
      stage_enable = $urandom & $urandom;
      stage_rule   = 4'($urandom);
      stage_count  = {$urandom, $urandom} & 64'h0003_0003_0003_0003;
      num_stages   = 3'($urandom_range(0, 7));
      step();
      chk($sformatf("rand[%0d]", i),
          {m_out, (m_phase == 2), (m_phase == 1), 2'(m_stage)});
    end
    use_model = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_hdlverifier_capture_trigger_sequencer
`default_nettype wire
